map_port_arbiter: RTL
=====================

Name: map_port_arbiter

Overview:
- Shares the single-port 220-entry x 3-bit world map RAM among three requesters:
  - graphics reader (gfx), which must keep up with VGA scan-out;
  - robot sensor evaluator (sen), which issues up to 4 reads per robot step;
  - trash remover (trs), which writes 0 to a cleared cell.
- Sits in world between those requesters and the map RAM.
- Issues one RAM access per cycle, returns tagged read data, substitutes a wall code for off-map addresses and prevents starvation.

Parameters:
- ADDR_W, 8, map address width; valid addresses are 1..MAP_CELLS.
- DATA_W, 3, map cell width.
- MAP_CELLS, 220, highest valid address.
- WALL_CODE, 3'b001, read data returned for an off-map address.
- MAX_WAIT, 8, cycles a sen/trs request may wait before it overrides gfx priority.
- WAIT_W, 4, width of the wait counters; must hold MAX_WAIT.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- gfx_req  in  1  graphics read request.
- gfx_addr  in  ADDR_W  graphics read address.
- gfx_gnt  out  1  graphics request accepted this cycle.
- gfx_rvalid  out  1  rdata holds the graphics result.
- sen_req  in  1  sensor read request.
- sen_addr  in  ADDR_W  sensor read address.
- sen_gnt  out  1  sensor request accepted this cycle.
- sen_rvalid  out  1  rdata holds the sensor result.
- trs_req  in  1  trash write request.
- trs_addr  in  ADDR_W  trash write address.
- trs_wdata  in  DATA_W  value to write (normally 0).
- trs_gnt  out  1  write accepted this cycle.
- rdata  out  DATA_W  shared read-return data.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM synchronous read data, valid one cycle after address.

Behaviour:
- Reset (reset=0, async):
  - all gnt, rvalid and mem_we = 0; mem_addr, mem_wdata and rdata = 0.
  - Both wait counters = 0; rr pointer = 0.
  - Any in-flight read is discarded: no rvalid after reset release.
- Handshake:
  - A requester holds req, addr and wdata stable until it sees gnt high on a clock edge.
  - gnt is combinational in the same cycle, at most one gnt high per cycle.
  - A grant consumes exactly one access. A requester that keeps req high after gnt is treated as a new request.
- Arbitration, evaluated every cycle:
  1. starved = sen_req and sen_wait == MAX_WAIT, or trs_req and trs_wait == MAX_WAIT.
  2. If any requester is starved, the starved one wins. If both are starved, rr decides: rr=0 picks sen, rr=1 picks trs.
  3. Otherwise gfx wins if gfx_req is high.
  4. Otherwise, between sen and trs, rr decides the same way. A lone requester wins regardless of rr.
  5. rr toggles after every sen or trs grant; it is unchanged on a gfx grant.
- Wait counters (sen_wait, trs_wait):
  - Increment each cycle the owner requests and is not granted; saturate at MAX_WAIT.
  - Clear to 0 on grant or when req is low.
- Memory drive:
  - Winner's address goes to mem_addr.
  - mem_we = 1 only for a trs grant to a valid address; mem_wdata = trs_wdata.
  - With no winner: mem_we = 0, and mem_addr holds its last value. mem_addr is registered-hold, not combinational idle 0.
- Address validity: valid means 1 <= addr <= MAP_CELLS. For an off-map address:
  - gnt is still asserted and no RAM write occurs.
  - A read returns WALL_CODE instead of mem_rdata.
- Read return latency is exactly 1 cycle:
  - The cycle after a gfx or sen grant, the matching rvalid = 1 for one cycle.
  - rdata = mem_rdata, or WALL_CODE if the granted address was off-map.
  - rvalid and the off-map flag are registered.
  - rdata holds its last value when no rvalid is high.
  - Back-to-back grants produce back-to-back rvalids.
- A trs write produces no rvalid. A gfx/sen read granted one cycle after a trs write to the same address returns the new value; the RAM is write-first.
- Simultaneous gfx+sen+trs with no starvation: gfx wins. sen/trs counters increment and rr is unchanged.

Test Plan:
1. Reset mid-read: sen_req with sen_addr=45 granted, reset=0 in the next cycle → sen_rvalid stays 0, all outputs 0 and counters 0 while reset is low.
2. gfx continuous and sen_req held from cycle 0 → gfx granted cycles 0-7, sen_gnt in cycle 8 (wait hits 8), gfx resumes in cycle 9, sen_rvalid in cycle 9.
3. sen and trs both requesting continuously, gfx idle → grants alternate sen, trs, sen, trs starting from rr=0.
4. sen_addr=0 and then sen_addr=221 → each granted, sen_rvalid next cycle with rdata=3'b001, no RAM access observed as write.
5. trs writes 0 to address 100 (old value 7), then sen reads 100 next cycle → mem_we=1 for one cycle, then rdata=0 with sen_rvalid.
6. Burst of 4 sen reads (21, 41, 22, 2) with gfx idle → 4 consecutive sen_gnt, then 4 consecutive sen_rvalid with data matching RAM contents in order.

Source files
------------

// File: rtl/map_port_arbiter.sv
// Shares the single-port world map RAM among the graphics reader, the sensor evaluator
// and the trash remover. One access per cycle, tagged 1-cycle read return, wall code off-map.
module map_port_arbiter #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 3,
    parameter int          MAP_CELLS = 220,
    parameter logic [2:0]  WALL_CODE = 3'b001,
    parameter int          MAX_WAIT  = 8,
    parameter int          WAIT_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gfx_req,
    input  logic [ADDR_W-1:0] gfx_addr,
    output logic              gfx_gnt,
    output logic              gfx_rvalid,
    input  logic              sen_req,
    input  logic [ADDR_W-1:0] sen_addr,
    output logic              sen_gnt,
    output logic              sen_rvalid,
    input  logic              trs_req,
    input  logic [ADDR_W-1:0] trs_addr,
    input  logic [DATA_W-1:0] trs_wdata,
    output logic              trs_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a requester holds req/addr/wdata stable until it sees gnt high at a
    // clock edge; gnt is combinational, one-hot, and each gnt consumes exactly one access.

    logic [WAIT_W-1:0] sen_wait, trs_wait;
    logic              rr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              gfx_rvalid_q, sen_rvalid_q, offmap_q;

    logic              sen_starved, trs_starved;
    logic              pick_gfx, pick_sen, pick_trs;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_addr;
    logic              win_valid;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_W'(1)) && (a <= ADDR_W'(MAP_CELLS));
    endfunction

    always_comb begin
        pick_gfx    = 1'b0;
        pick_sen    = 1'b0;
        pick_trs    = 1'b0;
        sen_starved = sen_req && (sen_wait == WAIT_W'(MAX_WAIT));
        trs_starved = trs_req && (trs_wait == WAIT_W'(MAX_WAIT));
        if (sen_starved && trs_starved) begin
            pick_sen = ~rr;
            pick_trs = rr;
        end else if (sen_starved) begin
            pick_sen = 1'b1;
        end else if (trs_starved) begin
            pick_trs = 1'b1;
        end else if (gfx_req) begin
            pick_gfx = 1'b1;
        end else if (sen_req && trs_req) begin
            pick_sen = ~rr;
            pick_trs = rr;
        end else if (sen_req) begin
            pick_sen = 1'b1;
        end else if (trs_req) begin
            pick_trs = 1'b1;
        end
    end

    // Grants are forced low while reset is asserted so nothing reaches the RAM.
    assign gfx_gnt = pick_gfx & reset;
    assign sen_gnt = pick_sen & reset;
    assign trs_gnt = pick_trs & reset;
    assign any_gnt = gfx_gnt | sen_gnt | trs_gnt;

    always_comb begin
        win_addr = addr_q;
        if (gfx_gnt)      win_addr = gfx_addr;
        else if (sen_gnt) win_addr = sen_addr;
        else if (trs_gnt) win_addr = trs_addr;
    end

    assign win_valid  = addr_ok(win_addr);
    assign mem_addr   = any_gnt ? win_addr : addr_q;
    assign mem_we     = trs_gnt && win_valid;
    assign mem_wdata  = trs_gnt ? trs_wdata : '0;

    assign gfx_rvalid = gfx_rvalid_q;
    assign sen_rvalid = sen_rvalid_q;
    assign rdata      = (gfx_rvalid_q || sen_rvalid_q) ?
                        (offmap_q ? DATA_W'(WALL_CODE) : mem_rdata) : rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sen_wait     <= '0;
            trs_wait     <= '0;
            rr           <= 1'b0;
            addr_q       <= '0;
            rdata_q      <= '0;
            gfx_rvalid_q <= 1'b0;
            sen_rvalid_q <= 1'b0;
            offmap_q     <= 1'b0;
        end else begin
            addr_q       <= mem_addr;
            rdata_q      <= rdata;
            gfx_rvalid_q <= gfx_gnt;
            sen_rvalid_q <= sen_gnt;
            offmap_q     <= ~win_valid;
            if (sen_gnt || trs_gnt)
                rr <= ~rr;
            if (sen_req && !sen_gnt)
                sen_wait <= (sen_wait == WAIT_W'(MAX_WAIT)) ? sen_wait : sen_wait + WAIT_W'(1);
            else
                sen_wait <= '0;
            if (trs_req && !trs_gnt)
                trs_wait <= (trs_wait == WAIT_W'(MAX_WAIT)) ? trs_wait : trs_wait + WAIT_W'(1);
            else
                trs_wait <= '0;
        end
    end

endmodule
